line_buffer_reader: RTL and testbench

LINE_BUFFER_READER -- requirements
Module: line_buffer_reader

---
 rtl/line_buffer_reader.sv | 133 +++++++++++++
 tb/tb_line_buffer_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_reader.sv
// Double-buffered line store between the engine array and a pixel stream.
// The writer fills one bank while the reader streams the other, one pixel per two cycles at most.
module line_buffer_reader #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int DEPTH_WIDTH   = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            start_out,
  input  logic                            line_done_in,
  input  logic                            we_in,
  input  logic [$clog2(SCREEN_WIDTH)-1:0] addr_in,
  input  logic [DEPTH_WIDTH-1:0]          depth_in,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DEPTH_WIDTH-1:0]          m_data,
  output logic                            m_last,
  output logic                            m_user
);

  localparam int AW = $clog2(SCREEN_WIDTH);
  localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam logic [AW:0]   X_LIMIT = (AW+1)'(SCREEN_WIDTH);
  localparam logic [AW-1:0] X_LAST  = AW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(SCREEN_HEIGHT - 1);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic [DEPTH_WIDTH-1:0] mem [2][SCREEN_WIDTH];
  logic [1:0]    full;
  logic          wb;
  logic          rb;
  logic          ld_q;
  logic [AW-1:0] x;
  logic [YW-1:0] y;

  logic line_rise;
  logic write_ok;
  logic commit;
  logic handshake;
  logic line_end;

  assign line_rise = line_done_in & ~ld_q;
  assign write_ok  = (wstate == W_FILL) && we_in && ({1'b0, addr_in} < X_LIMIT);
  assign commit    = (wstate == W_FILL) && line_rise;
  assign handshake = (rstate == R_STREAM) && m_ready;
  assign line_end  = handshake && (x == X_LAST);

  // Writer FSM
  always_ff @(posedge clk) begin
    if (reset) wstate <= W_IDLE;
    else       wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:  if (!full[wb]) wstate_nxt = W_FILL;
      W_FILL:  if (line_rise) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // Gated by reset so the request cannot leak out while the banks are being cleared.
  always_comb begin
    start_out = !reset && (wstate == W_IDLE) && !full[wb];
  end

  // Reader FSM
  always_ff @(posedge clk) begin
    if (reset) rstate <= R_IDLE;
    else       rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:   if (full[rb]) rstate_nxt = R_FETCH;
      R_FETCH:  rstate_nxt = R_STREAM;
      R_STREAM: if (m_ready) rstate_nxt = line_end ? R_IDLE : R_FETCH;
      default:  rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    m_valid = (rstate == R_STREAM);
  end

  always_ff @(posedge clk) begin
    if (write_ok) mem[wb][addr_in] <= depth_in;
  end

  // Writer only ever fills an empty bank and reader only drains a full one,
  // so the set and clear below always target different bits of full.
  always_ff @(posedge clk) begin
    if (reset) begin
      full   <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      ld_q   <= 1'b0;
      x      <= '0;
      y      <= '0;
      m_data <= '0;
      m_last <= 1'b0;
      m_user <= 1'b0;
    end else begin
      ld_q <= line_done_in;
      if (commit) begin
        full[wb] <= 1'b1;
        wb       <= ~wb;
      end
      if (line_end) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
        x        <= '0;
        y        <= (y == Y_LAST) ? '0 : y + YW'(1);
      end else if (handshake) begin
        x <= x + AW'(1);
      end
      if (rstate == R_FETCH) begin
        m_data <= mem[rb][x];
        m_last <= (x == X_LAST);
        m_user <= (x == '0) && (y == '0);
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_reader.sv
// Bench for line_buffer_reader: a line-level model (queue of committed lines) checked every cycle,
// randomized fills and backpressure, plus directed scenarios with literal expectations.
module tb_line_buffer_reader;
  localparam int W  = 8;
  localparam int H  = 2;
  localparam int DW = 10;
  localparam int AW = 3;
  localparam int W6 = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start_out, m_valid, m_last, m_user;
  logic          line_done_in = 1'b0, we_in = 1'b0, m_ready = 1'b1;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] depth_in = '0, m_data;

  logic          s_start, s_valid, s_last, s_user;
  logic          s_ld = 1'b0, s_we = 1'b0, s_ready = 1'b1;
  logic [2:0]    s_addr = '0;
  logic [DW-1:0] s_depth = '0, s_data;

  line_buffer_reader #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .DEPTH_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start_out(start_out), .line_done_in(line_done_in),
    .we_in(we_in), .addr_in(addr_in), .depth_in(depth_in), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_user(m_user));

  // Narrow instance: with 6 pixels a 3-bit address can point past the end of the line.
  line_buffer_reader #(.SCREEN_WIDTH(W6), .SCREEN_HEIGHT(H), .DEPTH_WIDTH(DW)) dut6 (
    .clk(clk), .reset(reset), .start_out(s_start), .line_done_in(s_ld),
    .we_in(s_we), .addr_in(s_addr), .depth_in(s_depth), .m_valid(s_valid),
    .m_ready(s_ready), .m_data(s_data), .m_last(s_last), .m_user(s_user));

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model state: lines committed but not yet fully streamed, plus the line being filled.
  logic [W*DW-1:0] lines[$];
  logic [DW+1:0]   beats[$];
  logic [DW-1:0]   cur [W];
  bit filling = 1'b0;
  bit ld_prev = 1'b0;
  bit rst_prev = 1'b1;
  bit hs_prev = 1'b0;
  bit stall_prev = 1'b0;
  int px = 0;
  int yline = 0;

  initial begin
    bit exp_start, hs, rise;
    logic [W*DW-1:0] head;
    logic [DW-1:0] exp_d;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_start = !reset && !filling && (lines.size() < 2);
      check("start_out", int'(start_out), int'(exp_start));
      if (rst_prev) begin
        check("rst_valid", int'(m_valid), 0);
        check("rst_data", int'(m_data), 0);
        check("rst_last", int'(m_last), 0);
        check("rst_user", int'(m_user), 0);
      end else begin
        if (m_valid) begin
          check("no_stale_line", int'(lines.size() != 0), 1);
          if (lines.size() != 0) begin
            head  = lines[0];
            exp_d = head[px*DW +: DW];
            check("m_data", int'(m_data), int'(exp_d));
            check("m_last", int'(m_last), int'(px == W-1));
            check("m_user", int'(m_user), int'(px == 0 && yline == 0));
          end
        end
        if (stall_prev) check("hold_valid", int'(m_valid), 1);
        if (hs_prev) check("gap_after_beat", int'(m_valid), 0);
      end
      hs = m_valid && m_ready;
      if (reset) begin
        lines.delete();
        filling = 1'b0;
        ld_prev = 1'b0;
        px = 0;
        yline = 0;
      end else begin
        rise = line_done_in && !ld_prev;
        if (filling && we_in && int'(addr_in) < W) cur[addr_in] = depth_in;
        if (filling && rise) begin
          for (int i = 0; i < W; i++) head[i*DW +: DW] = cur[i];
          lines.push_back(head);
          filling = 1'b0;
        end else if (exp_start) begin
          filling = 1'b1;
        end
        ld_prev = line_done_in;
        if (hs && lines.size() != 0) begin
          beats.push_back({m_user, m_last, m_data});
          px++;
          if (px == W) begin
            void'(lines.pop_front());
            px = 0;
            yline = (yline + 1) % H;
          end
        end
      end
      rst_prev   = reset;
      hs_prev    = hs && !reset;
      stall_prev = m_valid && !m_ready && !reset;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ascending x, depth base+x; mode 1: descending; mode 2: random order/gaps/overwrites/strays.
  task automatic fill_line(input int mode, input int base);
    int order[W];
    int n;
    int j;
    int t;
    n = 0;
    while (!filling) begin
      if (n == 300) begin
        check("wait_fill_timeout", 1, 0);
        we_in = 1'b0;
        return;
      end
      we_in    = (mode == 2) && ($urandom_range(0, 1) == 1);
      addr_in  = AW'($urandom_range(0, W-1));
      depth_in = DW'($urandom_range(0, 1023));
      step();
      n++;
    end
    for (int i = 0; i < W; i++) order[i] = (mode == 1) ? W-1-i : i;
    if (mode == 2) begin
      for (int i = W-1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
    end
    for (int i = 0; i < W; i++) begin
      if (mode == 2) begin
        while ($urandom_range(0, 3) == 0) begin
          we_in = 1'b0;
          step();
        end
      end
      we_in    = 1'b1;
      addr_in  = AW'(order[i]);
      depth_in = (mode == 2) ? DW'($urandom_range(0, 1023)) : DW'(base + order[i]);
      step();
    end
    if (mode == 2) begin
      repeat ($urandom_range(0, 2)) begin
        we_in    = 1'b1;
        addr_in  = AW'($urandom_range(0, W-1));
        depth_in = DW'($urandom_range(0, 1023));
        step();
      end
    end
    // In random mode the closing cycle may carry a write that still belongs to this line.
    we_in        = (mode == 2) && ($urandom_range(0, 1) == 1);
    addr_in      = AW'($urandom_range(0, W-1));
    depth_in     = DW'($urandom_range(0, 1023));
    line_done_in = 1'b1;
    step();
    line_done_in = 1'b0;
    we_in        = (mode == 2);
    addr_in      = AW'($urandom_range(0, W-1));
    depth_in     = DW'($urandom_range(0, 1023));
    step();
    we_in = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string name);
    int n;
    n = 0;
    while (beats.size() < target) begin
      if (n == 500) begin
        check(name, beats.size(), target);
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (lines.size() != 0) begin
      if (n == 600) begin
        check(name, lines.size(), 0);
        return;
      end
      step();
      n++;
    end
    repeat (2) step();
  endtask

  task automatic check_beat(input string name, input int idx, input int data, input int last, input int user);
    logic [DW+1:0] e;
    if (idx >= beats.size()) begin
      check({name, "_missing"}, beats.size(), idx + 1);
      return;
    end
    e = beats[idx];
    check({name, "_data"}, int'(e[DW-1:0]), data);
    check({name, "_last"}, int'(e[DW]), last);
    check({name, "_user"}, int'(e[DW+1]), user);
  endtask

  initial begin
    int b;
    int n;
    int k;
    int cnt;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("start_after_reset", int'(start_out), 1);
    check("w6_start_after_reset", int'(s_start), 1);
    step();

    // Narrow instance: reverse-order writes, then two addresses beyond the line end.
    for (int x = W6-1; x >= 0; x--) begin
      s_we = 1'b1; s_addr = 3'(x); s_depth = DW'(x + 1);
      step();
    end
    s_addr = 3'd7; s_depth = DW'(99);
    step();
    s_addr = 3'd6; s_depth = DW'(98);
    step();
    s_we = 1'b0; s_ld = 1'b1;
    step();
    s_ld = 1'b0;
    k = 0;
    n = 0;
    while (k < W6 && n < 100) begin
      @(negedge clk);
      if (s_valid) begin
        check("w6_data", int'(s_data), k + 1);
        check("w6_last", int'(s_last), int'(k == W6-1));
        check("w6_user", int'(s_user), int'(k == 0));
        k++;
      end
      n++;
    end
    check("w6_beats", k, W6);
    step();

    // Single line, ascending writes.
    b = beats.size();
    fill_line(0, 1);
    drain("t1_drain");
    for (int i = 0; i < W; i++) check_beat("t1", b + i, i + 1, int'(i == W-1), int'(i == 0));

    // Descending writes; second line of the frame carries no m_user.
    b = beats.size();
    fill_line(1, 10);
    drain("t2_drain");
    for (int i = 0; i < W; i++) check_beat("t2", b + i, 10 + i, int'(i == W-1), 0);

    // Five cycles of backpressure mid-line; frame wraps so m_user returns.
    b = beats.size();
    fill_line(0, 20);
    wait_beats(b + 3, "t3_beats_timeout");
    rdy_mode = 2;
    repeat (5) step();
    rdy_mode = 0;
    drain("t3_drain");
    check("t3_beat_count", beats.size() - b, W);
    for (int i = 0; i < W; i++) check_beat("t3", b + i, 20 + i, int'(i == W-1), int'(i == 0));

    // Reader stalled: both banks fill, third request withheld until the first line's last beat.
    rdy_mode = 2;
    b = beats.size();
    fill_line(0, 40);
    fill_line(0, 50);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (start_out) cnt++;
    end
    check("t4_third_start_withheld", cnt, 0);
    step();
    rdy_mode = 0;
    wait_beats(b + W, "t4_first_line_timeout");
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (start_out) cnt++;
    end
    check("t4_third_start_released", cnt, 1);
    step();
    fill_line(0, 60);
    drain("t4_drain");
    check_beat("t4_l0", b, 40, 0, 0);
    check_beat("t4_l1", b + W, 50, 0, 1);
    check_beat("t4_l2", b + 2*W + W-1, 67, 1, 0);

    // Reset during the stream aborts the line for good.
    b = beats.size();
    fill_line(0, 70);
    wait_beats(b + 3, "t5_beats_timeout");
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (12) step();
    check("t5_no_stale_beats", beats.size(), b + 3);
    fill_line(0, 80);
    drain("t5_drain");
    check_beat("t5_first", b + 3, 80, 0, 1);

    // Randomized fills against random backpressure.
    rdy_mode = 1;
    repeat (40) fill_line(2, 0);
    rdy_mode = 0;
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
